cvsd_pcm_decoder: RTL
=====================

Name: cvsd_pcm_decoder

Overview:
- CVSD receive path: converts the 1-bit delta stream produced by the CVSD coder back into 16-bit two's-complement PCM.
- Adds syllabic step adaptation, a run detector, a saturating integrator with optional leak, and a one-cycle output valid strobe.
- Sits at the far end of the serial link, downstream of the bit channel, and feeds the PCM sink/DAC interface.

Parameters:
- DATA_W, 16, PCM sample width (signed).
- STEP_MIN, 16, minimum step size; also the reset value.
- STEP_MAX, 4096, maximum step size.
- STEP_DELTA, 64, additive step increase on a detected run.
- DECAY_SHIFT, 4, step decay: step - (step >> DECAY_SHIFT).
- RUN_LEN, 3, number of equal consecutive bits that count as a run (>= 2).
- LEAK_SHIFT, 0, integrator leak: acc - (acc >>> LEAK_SHIFT); 0 disables the leak.

Ports:
- clk_i  input  1  system clock; all state updates on its rising edge.
- rst_i  input  1  synchronous, active-high reset; overrides every other input.
- enable_i  input  1  bit strobe; data_i is consumed on each rising edge where enable_i=1.
- data_i  input  1  CVSD bit; 1 = estimate too high (subtract step), 0 = estimate too low (add step). Polarity matches the coder.
- data_o  output  DATA_W  reconstructed PCM sample, signed.
- valid_o  output  1  one-cycle pulse: data_o has been updated from a consumed bit.
- overload_o  output  1  high while the current step equals STEP_MAX.

Behaviour:
- Reset values (rst_i=1 at an edge): data_o=0, valid_o=0, overload_o=0, step=STEP_MIN, history=0, fill counter=0.
- Reset is synchronous, active-high. If rst_i and enable_i are both high on the same edge, reset wins and the bit is discarded.
- Idle (enable_i=0): all state holds and valid_o=0.
- On an accepted bit b (edge N), compute in this order:
  1. History: shift b into a RUN_LEN-deep history register; the fill counter increments and saturates at RUN_LEN.
  2. Run: run = (fill counter after update == RUN_LEN) && all RUN_LEN history bits are equal, with b included. No run is possible until RUN_LEN bits have been received since reset.
  3. Step, if run: step_next = min(step + STEP_DELTA, STEP_MAX).
  4. Step, if no run: step_next = max(step - (step >> DECAY_SHIFT), STEP_MIN).
  5. Integrator: acc_l = acc - (acc >>> LEAK_SHIFT) when LEAK_SHIFT != 0, else acc. Then acc_next = acc_l - step_next when b=1, or acc_l + step_next when b=0.
  6. Saturation: acc_next is computed at DATA_W+2 bits and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. The stored accumulator is always the clamped value.
- Latency: data_o = acc_next, valid_o=1 and overload_o=(step_next==STEP_MAX) are all visible in the cycle after edge N.
- Back-to-back bits (enable_i held high): one sample per cycle; valid_o stays high continuously.
- overload_o updates only on accepted bits and holds otherwise.
- No wrap-around is allowed anywhere: step and accumulator always saturate.

Decomposition:
- Package cvsd_pkg holds:
  - the default constants DATA_W, STEP_MIN, STEP_MAX, STEP_DELTA;
  - a saturate-to-DATA_W function;
  - a step-limit clamp function.
- These are shared with the coder/decoder pair.
- Sub-module cvsd_step_adapt contains the history register, fill counter, run detector and step register, with outputs step_next and at_max. The top level holds the integrator, leak, saturation and output registers.

Test Plan:
1. Reset, then a single bit 0 with enable_i=1 -> next cycle data_o=16, valid_o=1 for exactly one cycle, step stays 16 (decay clamped), overload_o=0.
2. Reset, then bits 0,0,0 on consecutive cycles -> data_o=16, 32, 112 (the third bit triggers a run, step=80); valid_o high for 3 cycles.
3. Reset, then bits 1,0,1,0 -> data_o=-16, 0, -16, 0; step remains 16; overload_o=0 throughout.
4. Reset, then 200 consecutive 0 bits -> step clamps at 4096 and overload_o=1; data_o saturates at 32767 and never wraps. A following bit 1 -> step=3840, data_o=28927, overload_o=0.
5. Bits 0,0 with enable_i low for 5 cycles between them -> data_o holds 16 and valid_o=0 during the gap; the second bit gives data_o=32 (no run yet, fill=2).
6. Mid-stream after test 2, rst_i=1 together with enable_i=1, data_i=0 -> next cycle data_o=0, valid_o=0, overload_o=0. A subsequent bit 0 gives data_o=16 (history cleared, no run).

Source files
------------

// File: rtl/cvsd_pkg.sv
// Purpose: constants and clamp helpers shared by the CVSD coder/decoder pair.
// Latency: n/a (pure functions and constants).
// Backpressure: n/a.
package cvsd_pkg;

    localparam int DATA_W     = 16;
    localparam int STEP_MIN   = 16;
    localparam int STEP_MAX   = 4096;
    localparam int STEP_DELTA = 64;
    // Step register width; comfortably holds STEP_MAX.
    localparam int STEP_W     = 16;

    // PCM limits expressed at the 2-bit-wider integrator width.
    localparam logic signed [DATA_W+1:0] PCM_HI = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W+1:0] PCM_LO = {3'b111, {(DATA_W-1){1'b0}}};

    // Clamp a wide integrator result into the signed PCM range.
    function automatic logic signed [DATA_W-1:0] sat_pcm(input logic signed [DATA_W+1:0] v);
        logic signed [DATA_W+1:0] r;
        r = v;
        if (v > PCM_HI) begin
            r = PCM_HI;
        end else if (v < PCM_LO) begin
            r = PCM_LO;
        end
        return $signed(r[DATA_W-1:0]);
    endfunction

    // Clamp a one-bit-wider step candidate into [lo, hi].
    function automatic logic [STEP_W-1:0] step_limit(input logic [STEP_W:0] v,
                                                     input logic [STEP_W:0] lo,
                                                     input logic [STEP_W:0] hi);
        logic [STEP_W:0] r;
        r = v;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end
        return r[STEP_W-1:0];
    endfunction

endpackage

// File: rtl/cvsd_pcm_decoder_if.sv
// Purpose: bit-stream in / PCM out bundle of the CVSD decoder.
// Latency: n/a (wires only).
// Backpressure: none; the decoder always accepts a strobed bit.
// Ports: enable_i/data_i (bit strobe + CVSD bit), data_o/valid_o/overload_o (PCM side).
interface cvsd_pcm_decoder_if #(
    parameter int DATA_W = cvsd_pkg::DATA_W
);
    logic                     enable_i;
    logic                     data_i;
    logic signed [DATA_W-1:0] data_o;
    logic                     valid_o;
    logic                     overload_o;

    // master drives the bit stream and sinks PCM; slave is the decoder.
    modport master (output enable_i, data_i, input data_o, valid_o, overload_o);
    modport slave  (input enable_i, data_i, output data_o, valid_o, overload_o);
endinterface

// File: rtl/cvsd_step_adapt.sv
// Purpose: syllabic step adaptation: bit history, fill counter, run detect, step register.
// Latency: step_next/at_max are combinational from the current bit; state updates on accept.
// Backpressure: none; state advances on every enable_i edge.
// Ports: clk_i, rst_i, enable_i, bit_i in; step_next (step for this bit), at_max out.
module cvsd_step_adapt #(
    parameter int STEP_MIN    = cvsd_pkg::STEP_MIN,
    parameter int STEP_MAX    = cvsd_pkg::STEP_MAX,
    parameter int STEP_DELTA  = cvsd_pkg::STEP_DELTA,
    parameter int DECAY_SHIFT = 4,
    parameter int RUN_LEN     = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          bit_i,
    output logic [cvsd_pkg::STEP_W-1:0]   step_next,
    output logic                          at_max
);
    import cvsd_pkg::*;

    localparam int FILL_W = $clog2(RUN_LEN + 1);

    logic [RUN_LEN-1:0] hist, hist_nxt;
    logic [FILL_W-1:0]  fill, fill_nxt;
    logic [STEP_W-1:0]  step;
    logic [STEP_W:0]    step_inc, step_dec;
    logic               run;

    always_comb begin
        hist_nxt = {hist[RUN_LEN-2:0], bit_i};
        fill_nxt = (fill == FILL_W'(RUN_LEN)) ? fill : fill + 1'b1;
        // The current bit is part of the window; a run needs a full window.
        run      = (fill_nxt == FILL_W'(RUN_LEN)) && ((&hist_nxt) || !(|hist_nxt));
        // One extra bit so the increment cannot wrap before the clamp.
        step_inc = {1'b0, step} + (STEP_W+1)'(STEP_DELTA);
        step_dec = {1'b0, step - (step >> DECAY_SHIFT)};
        step_next = step_limit(run ? step_inc : step_dec,
                               (STEP_W+1)'(STEP_MIN), (STEP_W+1)'(STEP_MAX));
        at_max   = (step_next == STEP_W'(STEP_MAX));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist <= '0;
            fill <= '0;
            step <= STEP_W'(STEP_MIN);
        end else if (enable_i) begin
            hist <= hist_nxt;
            fill <= fill_nxt;
            step <= step_next;
        end
    end

endmodule

// File: rtl/cvsd_pcm_decoder.sv
// Purpose: CVSD receive path, 1-bit delta stream to signed PCM with adaptive step and leak.
// Latency: one cycle from an accepted bit to data_o/valid_o/overload_o.
// Backpressure: none; one sample per enable_i edge, valid_o is a per-sample strobe.
// Ports: clk_i, rst_i (sync, active high); bus (slave): enable_i, data_i in; data_o, valid_o, overload_o out.
module cvsd_pcm_decoder #(
    parameter int DATA_W      = cvsd_pkg::DATA_W,
    parameter int STEP_MIN    = cvsd_pkg::STEP_MIN,
    parameter int STEP_MAX    = cvsd_pkg::STEP_MAX,
    parameter int STEP_DELTA  = cvsd_pkg::STEP_DELTA,
    parameter int DECAY_SHIFT = 4,
    parameter int RUN_LEN     = 3,
    parameter int LEAK_SHIFT  = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    cvsd_pcm_decoder_if.slave  bus
);
    import cvsd_pkg::*;

    logic [STEP_W-1:0]        step_next;
    logic                     at_max;
    logic signed [DATA_W-1:0] acc, acc_l;
    logic signed [DATA_W+1:0] acc_ext, step_ext, acc_wide;
    logic                     valid_q, ovl_q;

    cvsd_step_adapt #(
        .STEP_MIN    (STEP_MIN),
        .STEP_MAX    (STEP_MAX),
        .STEP_DELTA  (STEP_DELTA),
        .DECAY_SHIFT (DECAY_SHIFT),
        .RUN_LEN     (RUN_LEN)
    ) u_step (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .enable_i  (bus.enable_i),
        .bit_i     (bus.data_i),
        .step_next (step_next),
        .at_max    (at_max)
    );

    always_comb begin
        // acc >>> 0 would cancel the whole accumulator, so a zero shift means no leak.
        acc_l = acc;
        if (LEAK_SHIFT != 0) begin
            acc_l = acc - (acc >>> LEAK_SHIFT);
        end
        // Integrate at two extra bits so the clamp sees the true overshoot.
        acc_ext  = {{2{acc_l[DATA_W-1]}}, acc_l};
        step_ext = $signed((DATA_W+2)'(step_next));
        acc_wide = bus.data_i ? (acc_ext - step_ext) : (acc_ext + step_ext);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc     <= '0;
            valid_q <= 1'b0;
            ovl_q   <= 1'b0;
        end else if (bus.enable_i) begin
            acc     <= sat_pcm(acc_wide);
            valid_q <= 1'b1;
            ovl_q   <= at_max;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.data_o     = acc;
    assign bus.valid_o    = valid_q;
    assign bus.overload_o = ovl_q;

endmodule
